ekf_stage_sched: RTL and testbench

// - Command scheduler in front of the RSA/NonLinear EKF datapath. Queues host step commands (PREDICT, NEWLM, UPDATE).
// - Issues commands one at a time over the stage_val/stage_rdy handshake.
// - Drives and holds the per-stage operands, and owns the landmark_num map counter.
// - Rejects illegal commands and detects stalled stages by timeout.

---
 rtl/ekf_stage_sched.sv | 254 +++++++++++++++++++++++++
 tb/tb_ekf_stage_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ekf_stage_sched.sv
// ============================================================================
// Module      : ekf_stage_sched
// Description : Command scheduler for the EKF datapath. It queues host step
//               commands, issues them over a stage handshake, holds the stage
//               operands, counts map landmarks and reports errors/timeouts.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ekf_stage_sched #(
  parameter int DEPTH  = 4,
  parameter int MAX_LM = 1023,
  parameter int TO_W   = 16
) (
  input  logic        clk,
  input  logic        sys_rst,
  input  logic        cmd_val,
  output logic        cmd_rdy,
  input  logic [1:0]  cmd_op,
  input  logic [9:0]  cmd_lk,
  input  logic [31:0] cmd_d0,
  input  logic [31:0] cmd_d1,
  output logic [2:0]  stage_val,
  input  logic [2:0]  stage_rdy,
  output logic [9:0]  landmark_num,
  output logic [9:0]  l_k,
  output logic [31:0] vlr,
  output logic [31:0] alpha,
  output logic [31:0] rk,
  output logic [31:0] phi,
  output logic        busy,
  output logic        done_val,
  output logic [1:0]  done_op,
  output logic        err_val,
  output logic [1:0]  err_code
);

  localparam int              c_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_CW     = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH  = c_CW'(DEPTH);
  localparam logic [9:0]      c_MAX_LM = 10'(MAX_LM);
  localparam logic [1:0]      c_OP_PREDICT = 2'd0;
  localparam logic [1:0]      c_OP_NEWLM   = 2'd1;
  localparam logic [1:0]      c_OP_UPDATE  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_ERR     = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [75:0]       r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_count;
  logic              w_push;
  logic              w_pop;
  logic [75:0]       w_head;
  logic [1:0]        w_h_op;
  logic [9:0]        w_h_lk;
  logic [31:0]       w_h_d0;
  logic [31:0]       w_h_d1;

  logic [1:0]        r_op;
  logic [1:0]        r_err_code;
  logic              r_done_val;
  logic [9:0]        r_lm;
  logic [9:0]        r_lk;
  logic [31:0]       r_vlr;
  logic [31:0]       r_alpha;
  logic [31:0]       r_rk;
  logic [31:0]       r_phi;
  logic [TO_W-1:0]   r_to;

  logic              w_load;
  logic              w_err_set;
  logic [1:0]        w_err_code;
  logic              w_done;
  logic              w_op_rdy;
  logic              w_to_hit;
  logic              w_active;

  // ---------------------------------------------------------------- FIFO
  // cmd_rdy is taken from the registered count, so a same-cycle pop never
  // opens a slot for a push into a full queue.
  assign cmd_rdy = (r_count < c_DEPTH);
  assign w_push  = cmd_val & cmd_rdy;
  assign w_head  = r_mem[r_rd_ptr];
  assign w_h_op  = w_head[75:74];
  assign w_h_lk  = w_head[73:64];
  assign w_h_d0  = w_head[63:32];
  assign w_h_d1  = w_head[31:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_op, cmd_lk, cmd_d0, cmd_d1};
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  always_comb begin
    w_op_rdy = 1'b0;
    case (r_op)
      2'd0:    w_op_rdy = stage_rdy[0];
      2'd1:    w_op_rdy = stage_rdy[1];
      2'd2:    w_op_rdy = stage_rdy[2];
      default: w_op_rdy = 1'b0;
    endcase
  end

  assign w_to_hit = &r_to;
  assign w_active = (r_state == S_ISSUE) || (r_state == S_WAIT_LO) ||
                    (r_state == S_WAIT_HI);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_err_set   = 1'b0;
    w_err_code  = 2'd0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_h_op == 2'd3) begin
            w_err_set   = 1'b1;
            w_err_code  = 2'd0;
            w_state_nxt = S_ERR;
          end else if (w_h_op == c_OP_UPDATE && w_h_lk >= r_lm) begin
            w_err_set   = 1'b1;
            w_err_code  = 2'd1;
            w_state_nxt = S_ERR;
          end else if (w_h_op == c_OP_NEWLM && r_lm == c_MAX_LM) begin
            w_err_set   = 1'b1;
            w_err_code  = 2'd2;
            w_state_nxt = S_ERR;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE, S_WAIT_LO, S_WAIT_HI: begin
        if (w_to_hit) begin
          w_err_set   = 1'b1;
          w_err_code  = 2'd3;
          w_state_nxt = S_ERR;
        end else if (r_state == S_ISSUE && w_op_rdy) begin
          w_state_nxt = S_WAIT_LO;
        end else if (r_state == S_WAIT_LO && !w_op_rdy) begin
          w_state_nxt = S_WAIT_HI;
        end else if (r_state == S_WAIT_HI && w_op_rdy) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_op       <= 2'd0;
      r_err_code <= 2'd0;
      r_done_val <= 1'b0;
      r_lm       <= 10'd0;
      r_lk       <= 10'd0;
      r_vlr      <= 32'd0;
      r_alpha    <= 32'd0;
      r_rk       <= 32'd0;
      r_phi      <= 32'd0;
      r_to       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_done_val <= w_done;
      if (w_pop)     r_op       <= w_h_op;
      if (w_err_set) r_err_code <= w_err_code;
      if (w_load) begin
        case (w_h_op)
          c_OP_PREDICT: begin
            r_vlr   <= w_h_d0;
            r_alpha <= w_h_d1;
          end
          c_OP_NEWLM: begin
            r_rk  <= w_h_d0;
            r_phi <= w_h_d1;
            r_lk  <= r_lm;
          end
          default: begin
            r_rk  <= w_h_d0;
            r_phi <= w_h_d1;
            r_lk  <= w_h_lk;
          end
        endcase
      end
      // The map grows on the same edge that raises done_val for a NEWLM.
      if (w_done && r_op == c_OP_NEWLM) r_lm <= r_lm + 10'd1;
      if (w_load)        r_to <= '0;
      else if (w_active) r_to <= r_to + 1'b1;
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    stage_val = 3'b000;
    if (r_state == S_ISSUE) begin
      case (r_op)
        2'd0:    stage_val = 3'b001;
        2'd1:    stage_val = 3'b010;
        2'd2:    stage_val = 3'b100;
        default: stage_val = 3'b000;
      endcase
    end
  end

  assign landmark_num = r_lm;
  assign l_k          = r_lk;
  assign vlr          = r_vlr;
  assign alpha        = r_alpha;
  assign rk           = r_rk;
  assign phi          = r_phi;
  assign busy         = (r_state != S_IDLE) || (r_count != '0);
  assign done_val     = r_done_val;
  assign done_op      = r_op;
  assign err_val      = (r_state == S_ERR);
  assign err_code     = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_ekf_stage_sched.sv
// ============================================================================
// Module      : tb_ekf_stage_sched
// Description : Self-checking bench for ekf_stage_sched against a command-level
//               reference model (map size, operand registers, error rules).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ekf_stage_sched;

  localparam int DEPTH  = 4;
  localparam int MAX_LM = 4;
  localparam int TO_W   = 6;

  logic        clk;
  logic        sys_rst;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_lk;
  logic [31:0] cmd_d0;
  logic [31:0] cmd_d1;
  logic [2:0]  stage_val;
  logic [2:0]  stage_rdy;
  logic [9:0]  landmark_num;
  logic [9:0]  l_k;
  logic [31:0] vlr;
  logic [31:0] alpha;
  logic [31:0] rk;
  logic [31:0] phi;
  logic        busy;
  logic        done_val;
  logic [1:0]  done_op;
  logic        err_val;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_lm;
  logic [9:0]  m_lk;
  logic [31:0] m_vlr, m_alpha, m_rk, m_phi;

  ekf_stage_sched #(.DEPTH(DEPTH), .MAX_LM(MAX_LM), .TO_W(TO_W)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_lk(cmd_lk),
    .cmd_d0(cmd_d0), .cmd_d1(cmd_d1),
    .stage_val(stage_val), .stage_rdy(stage_rdy),
    .landmark_num(landmark_num), .l_k(l_k),
    .vlr(vlr), .alpha(alpha), .rk(rk), .phi(phi),
    .busy(busy), .done_val(done_val), .done_op(done_op),
    .err_val(err_val), .err_code(err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [9:0] lk,
                          input logic [31:0] d0, input logic [31:0] d1);
    int t;
    t = 0;
    cmd_val = 1'b1; cmd_op = op; cmd_lk = lk; cmd_d0 = d0; cmd_d1 = d1;
    while (!cmd_rdy && t < 300) begin step(); t++; end
    chk("push_rdy", 32'(cmd_rdy), 32'd1);
    step();
    cmd_val = 1'b0;
  endtask

  // mode 0: normal RSA response (drop k cycles after handshake, raise m later)
  // mode 1: stage never ready -> timeout in ISSUE
  // mode 2: stage never starts -> timeout in WAIT_LO
  task automatic expect_cmd(input logic [1:0] op, input logic [9:0] lk,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input int mode, input int k, input int m);
    int  t;
    int  ecode;
    bit  exp_err;
    exp_err = 1'b1;
    ecode   = 0;
    if (op == 2'd3)                       ecode = 0;
    else if (op == 2'd2 && int'(lk) >= m_lm) ecode = 1;
    else if (op == 2'd1 && m_lm == MAX_LM)   ecode = 2;
    else                                  exp_err = 1'b0;
    stage_rdy = (mode == 1) ? 3'b000 : 3'b111;
    t = 0;
    while (stage_val == 3'b000 && !err_val && t < 40) begin step(); t++; end
    if (exp_err) begin
      chk("err_val", 32'(err_val), 32'd1);
      chk("err_code", 32'(err_code), 32'(ecode));
      chk("err_op", 32'(done_op), 32'(op));
      chk("err_no_issue", 32'(stage_val), 32'd0);
      chk("err_lm", 32'(landmark_num), 32'(m_lm));
      step();
      chk("err_pulse", 32'(err_val), 32'd0);
    end else begin
      if (op == 2'd0) begin
        m_vlr = d0; m_alpha = d1;
      end else begin
        m_rk = d0; m_phi = d1;
        m_lk = (op == 2'd1) ? 10'(m_lm) : lk;
      end
      chk("issue_sv", 32'(stage_val), 32'(3'b001 << op));
      chk("issue_noerr", 32'(err_val), 32'd0);
      chk("vlr", vlr, m_vlr);
      chk("alpha", alpha, m_alpha);
      chk("rk", rk, m_rk);
      chk("phi", phi, m_phi);
      chk("l_k", 32'(l_k), 32'(m_lk));
      if (mode == 0) begin
        step();
        chk("sv_drop", 32'(stage_val), 32'd0);
        repeat (k) step();
        stage_rdy[op] = 1'b0;
        step();
        repeat (m) step();
        stage_rdy[op] = 1'b1;
        step();
        if (op == 2'd1) m_lm++;
        chk("done_val", 32'(done_val), 32'd1);
        chk("done_op", 32'(done_op), 32'(op));
        chk("done_lm", 32'(landmark_num), 32'(m_lm));
        step();
        chk("done_pulse", 32'(done_val), 32'd0);
      end else begin
        t = 0;
        while (!err_val && t < 200) begin step(); t++; end
        chk("to_err_val", 32'(err_val), 32'd1);
        chk("to_err_code", 32'(err_code), 32'd3);
        chk("to_sv", 32'(stage_val), 32'd0);
        chk("to_lm", 32'(landmark_num), 32'(m_lm));
        step();
        stage_rdy = 3'b111;
      end
    end
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [9:0]  r_lk;
    logic [31:0] r_d0, r_d1;
    int          sel, mode;

    sys_rst = 1'b1; cmd_val = 1'b0; cmd_op = 2'd0; cmd_lk = 10'd0;
    cmd_d0 = 32'd0; cmd_d1 = 32'd0; stage_rdy = 3'b111;
    m_lm = 0; m_lk = 10'd0; m_vlr = 32'd0; m_alpha = 32'd0; m_rk = 32'd0; m_phi = 32'd0;
    step(); step();
    chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("rst_stage_val", 32'(stage_val), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lm", 32'(landmark_num), 32'd0);
    chk("rst_done", 32'(done_val), 32'd0);
    chk("rst_err", 32'(err_val), 32'd0);
    sys_rst = 1'b0;
    step();

    // Directed sequence
    push_cmd(2'd0, 10'd0, 32'd100, -32'sd5);
    expect_cmd(2'd0, 10'd0, 32'd100, -32'sd5, 0, 2, 10);
    for (int i = 0; i < 3; i++) begin
      push_cmd(2'd1, 10'd0, 32'(i + 11), 32'(i + 21));
      expect_cmd(2'd1, 10'd0, 32'(i + 11), 32'(i + 21), 0, 1, 2);
    end
    chk("lm_after_3", 32'(landmark_num), 32'd3);
    push_cmd(2'd2, 10'd5, 32'd7, 32'd8);
    expect_cmd(2'd2, 10'd5, 32'd7, 32'd8, 0, 0, 0);
    push_cmd(2'd2, 10'd2, 32'd9, 32'd10);
    expect_cmd(2'd2, 10'd2, 32'd9, 32'd10, 0, 0, 1);
    push_cmd(2'd3, 10'd0, 32'd1, 32'd2);
    expect_cmd(2'd3, 10'd0, 32'd1, 32'd2, 0, 0, 0);
    push_cmd(2'd1, 10'd0, 32'd30, 32'd31);
    expect_cmd(2'd1, 10'd0, 32'd30, 32'd31, 0, 0, 0);
    push_cmd(2'd1, 10'd0, 32'd40, 32'd41);
    expect_cmd(2'd1, 10'd0, 32'd40, 32'd41, 0, 0, 0);

    // Back-to-back pushes with every stage stalled
    stage_rdy = 3'b000;
    for (int i = 0; i < 5; i++) begin
      cmd_val = 1'b1; cmd_op = 2'd0; cmd_lk = 10'd0;
      cmd_d0 = 32'(1000 + i); cmd_d1 = 32'(2000 + i);
      step();
    end
    cmd_val = 1'b0;
    chk("full_cmd_rdy", 32'(cmd_rdy), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    expect_cmd(2'd0, 10'd0, 32'd1000, 32'd2000, 1, 0, 0);
    for (int i = 1; i < 5; i++) begin
      expect_cmd(2'd0, 10'd0, 32'(1000 + i), 32'(2000 + i), 0, 1, 1);
      chk("drain_cmd_rdy", 32'(cmd_rdy), 32'd1);
    end

    // Reset while in WAIT_HI
    push_cmd(2'd0, 10'd0, 32'd77, 32'd88);
    stage_rdy = 3'b111;
    step();
    step();
    stage_rdy[0] = 1'b0;
    step();
    step();
    sys_rst = 1'b1;
    #1;
    chk("arst_sv", 32'(stage_val), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_lm", 32'(landmark_num), 32'd0);
    chk("arst_vlr", vlr, 32'd0);
    chk("arst_cmd_rdy", 32'(cmd_rdy), 32'd1);
    step();
    sys_rst = 1'b0;
    stage_rdy = 3'b111;
    step();
    chk("post_rst_lm", 32'(landmark_num), 32'd0);
    m_lm = 0; m_lk = 10'd0; m_vlr = 32'd0; m_alpha = 32'd0; m_rk = 32'd0; m_phi = 32'd0;

    // Randomized commands against the model
    for (int n = 0; n < 40; n++) begin
      sel  = int'($urandom_range(0, 9));
      r_op = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      r_lk = 10'($urandom_range(0, 5));
      r_d0 = $urandom;
      r_d1 = $urandom;
      sel  = int'($urandom_range(0, 11));
      mode = (sel == 0) ? 1 : (sel == 1) ? 2 : 0;
      push_cmd(r_op, r_lk, r_d0, r_d1);
      expect_cmd(r_op, r_lk, r_d0, r_d1, mode,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 8)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
